// File: rtl/fifo_ctrl_status_if.sv
// Handshake and status bundle between producer/consumer logic and the FIFO pointer controller.
// The master drives the requests and the slave (the controller) returns the RAM controls and status.
interface fifo_ctrl_status_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  w_en;
    logic                  r_en;
    logic                  clr;
    logic                  err_clr;
    logic                  we;
    logic                  re;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output w_en, r_en, clr, err_clr,
        input  we, re, w_addr, r_addr, count, empty, full,
               almost_empty, almost_full, overflow, underflow
    );

    modport slave (
        input  w_en, r_en, clr, err_clr,
        output we, re, w_addr, r_addr, count, empty, full,
               almost_empty, almost_full, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl_status.sv
// Pointer/status controller for a 2**ADDR_WIDTH-entry dual-port FIFO RAM: addresses, enables,
// occupancy, programmable almost flags, sticky overflow/underflow, and a synchronous flush.
module fifo_ctrl_status #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input logic              clk,
    input logic              reset,
    fifo_ctrl_status_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THRESH = PW'(AE_LEVEL);

    logic [PW-1:0] w_ptr_q, w_ptr_d;
    logic [PW-1:0] r_ptr_q, r_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic empty, full;
    logic w_accept, r_accept;
    logic we, re;

    // Pointers carry an extra wrap bit so full and empty are distinguishable with equal low bits.
    assign empty = (w_ptr_q == r_ptr_q);
    assign full  = (w_ptr_q[ADDR_WIDTH-1:0] == r_ptr_q[ADDR_WIDTH-1:0]) &&
                   (w_ptr_q[ADDR_WIDTH] != r_ptr_q[ADDR_WIDTH]);

    // Acceptance ignores clr so a flush never counts as a refused request.
    assign r_accept = bus.r_en & ~empty;
    assign w_accept = bus.w_en & (~full | r_accept);
    assign we       = w_accept & ~bus.clr;
    assign re       = r_accept & ~bus.clr;

    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        overflow_d  = (overflow_q & ~bus.err_clr) | (bus.w_en & ~w_accept);
        underflow_d = (underflow_q & ~bus.err_clr) | (bus.r_en & ~r_accept);
        if (bus.clr) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            count_d = '0;
        end else begin
            w_ptr_d = w_ptr_q + PW'(we);
            r_ptr_d = r_ptr_q + PW'(re);
            count_d = count_q + PW'(we) - PW'(re);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.we           = we;
    assign bus.re           = re;
    assign bus.w_addr       = w_ptr_q[ADDR_WIDTH-1:0];
    assign bus.r_addr       = r_ptr_q[ADDR_WIDTH-1:0];
    assign bus.count        = count_q;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_empty = (count_q <= AE_THRESH);
    assign bus.almost_full  = (count_q >= AF_THRESH);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule
